// File: rtl/weight_matrix_loader_pkg.sv
// Shared definitions for the weight matrix loader.
// - Loader FSM state encoding.
// - Geometry helpers (package length, matrix length, packages per matrix).
// - Layout check used by the top level to reject parameter sets where
//   whole packages do not tile a kernel matrix exactly.
// - Default-geometry localparams.
package weight_matrix_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  function automatic int unsigned package_len(input int unsigned dw, input int unsigned fw);
    return dw / fw;
  endfunction

  function automatic int unsigned matrix_len(input int unsigned ms, input int unsigned ks);
    return ms * ks * ks;
  endfunction

  function automatic int unsigned package_num(input int unsigned dw, input int unsigned fw,
                                              input int unsigned ms, input int unsigned ks);
    return matrix_len(ms, ks) / package_len(dw, fw);
  endfunction

  // True when FW divides DW and whole packages tile the matrix exactly.
  function automatic bit layout_ok(input int unsigned dw, input int unsigned fw,
                                   input int unsigned ms, input int unsigned ks);
    if (fw == 0 || dw % fw != 0) return 1'b0;
    if (package_len(dw, fw) == 0) return 1'b0;
    return (matrix_len(ms, ks) % package_len(dw, fw)) == 0;
  endfunction

  localparam int unsigned PACKAGE_LEN = package_len(512, 32);
  localparam int unsigned MATRIX_LEN  = matrix_len(32, 3);
  localparam int unsigned PACKAGE_NUM = package_num(512, 32, 32, 3);

endpackage

// File: rtl/weight_matrix_loader_bank_ctrl.sv
// Ping-pong bank occupancy for the weight register matrix.
// Ports:
//   clk_i, rst_i     clock, async active-high reset
//   last_accept_i    last package of a matrix accepted this cycle
//   release_i        conv engine done with bank sel_r_o
//   wb_o             bank currently being written
//   full_o           per-bank "holds a complete matrix" flags
//   set_pend_o       a full bit will be set on the next edge
//   sel_r_o          bank the conv engine must read
//   weight_valid_o   bank sel_r_o holds a complete matrix
module weight_bank_ctrl (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       last_accept_i,
  input  logic       release_i,
  output logic       wb_o,
  output logic [1:0] full_o,
  output logic       set_pend_o,
  output logic       sel_r_o,
  output logic       weight_valid_o
);

  logic       wb_q;
  logic       rb_q;
  logic       set_pend_q;
  logic       set_bank_q;
  logic [1:0] full_q;
  logic [1:0] full_d;
  logic       rel_ok;

  assign rel_ok = release_i && full_q[rb_q];

  // The full bit is set one edge after the last accept, when the matrix
  // latches that package; the bank is remembered because wb has already
  // toggled by then.
  always_comb begin
    full_d = full_q;
    if (rel_ok)     full_d[rb_q]       = 1'b0;
    if (set_pend_q) full_d[set_bank_q] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_q       <= 1'b0;
      rb_q       <= 1'b0;
      set_pend_q <= 1'b0;
      set_bank_q <= 1'b0;
      full_q     <= '0;
    end else begin
      full_q     <= full_d;
      set_pend_q <= last_accept_i;
      if (last_accept_i) begin
        set_bank_q <= wb_q;
        wb_q       <= ~wb_q;
      end
      if (rel_ok) rb_q <= ~rb_q;
    end
  end

  assign wb_o           = wb_q;
  assign full_o         = full_q;
  assign set_pend_o     = set_pend_q;
  assign sel_r_o        = rb_q;
  assign weight_valid_o = full_q[rb_q];

endmodule

// File: rtl/weight_matrix_loader.sv
// Producer end of the weight register matrix load interface.
// Accepts DW-bit packages with valid/ready and forwards them to the matrix
// one cycle later, PACKAGE_NUM packages per kernel matrix, filling two
// ping-pong banks that the conv engine returns with release pulses.
// Ports:
//   clk_i, rst_i        clock, async active-high reset
//   start_i             job start pulse (IDLE only), num_matrix_i matrices
//   data_i/data_valid_i/data_ready_o   package input handshake
//   en_o/sel_w_o/data_o shift enable, write bank, package to matrix
//   sel_r_o/weight_valid_o/release_i   read-side bank handshake
//   busy_o              not IDLE
//   done_o              one-cycle pulse at job end
module weight_matrix_loader
  import weight_matrix_loader_pkg::*;
#(
  parameter int unsigned FW = 32,
  parameter int unsigned DW = 512,
  parameter int unsigned MS = 32,
  parameter int unsigned KS = 3,
  parameter int unsigned CW = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [CW-1:0] num_matrix_i,
  input  logic [DW-1:0] data_i,
  input  logic          data_valid_i,
  output logic          data_ready_o,
  output logic          en_o,
  output logic          sel_w_o,
  output logic [DW-1:0] data_o,
  output logic          sel_r_o,
  output logic          weight_valid_o,
  input  logic          release_i,
  output logic          busy_o,
  output logic          done_o
);

  localparam int unsigned PKG_NUM = package_num(DW, FW, MS, KS);
  localparam int unsigned PW      = (PKG_NUM > 1) ? $clog2(PKG_NUM) : 1;
  localparam logic [PW-1:0] PKG_LAST = PW'(PKG_NUM - 1);

  if (!layout_ok(DW, FW, MS, KS)) begin : g_layout_check
    $error("weight_matrix_loader: packages do not tile the kernel matrix exactly");
  end

  state_e        state_q;
  state_e        state_d;
  logic          done_d;
  logic [PW-1:0] pkg_cnt_q;
  logic [CW-1:0] mat_cnt_q;
  logic [CW-1:0] num_q;
  logic          accept;
  logic          last_pkg;
  logic          last_mat;
  logic          last_accept;
  logic          wb;
  logic [1:0]    full;
  logic          set_pend;

  assign data_ready_o = (state_q == ST_LOAD) && !full[wb];
  assign accept       = data_ready_o && data_valid_i;
  assign last_pkg     = (pkg_cnt_q == PKG_LAST);
  assign last_mat     = (mat_cnt_q == num_q - CW'(1));
  assign last_accept  = accept && last_pkg;
  assign busy_o       = (state_q != ST_IDLE);

  weight_bank_ctrl u_bank_ctrl (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .last_accept_i  (last_accept),
    .release_i      (release_i),
    .wb_o           (wb),
    .full_o         (full),
    .set_pend_o     (set_pend),
    .sel_r_o        (sel_r_o),
    .weight_valid_o (weight_valid_o)
  );

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (num_matrix_i != '0) state_d = ST_LOAD;
          else                    done_d  = 1'b1;
        end
      end
      ST_LOAD: begin
        if (last_accept && last_mat) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // set_pend keeps us here until the final full bit has actually set.
        if (!set_pend && full == 2'b00) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      done_o    <= 1'b0;
      en_o      <= 1'b0;
      sel_w_o   <= 1'b0;
      data_o    <= '0;
      pkg_cnt_q <= '0;
      mat_cnt_q <= '0;
      num_q     <= '0;
    end else begin
      done_o <= done_d;
      en_o   <= accept;
      if (accept) begin
        data_o  <= data_i;
        sel_w_o <= wb;
        if (last_pkg) begin
          pkg_cnt_q <= '0;
          mat_cnt_q <= mat_cnt_q + CW'(1);
        end else begin
          pkg_cnt_q <= pkg_cnt_q + PW'(1);
        end
      end
      if (state_q == ST_IDLE && start_i) begin
        num_q     <= num_matrix_i;
        mat_cnt_q <= '0;
        pkg_cnt_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_weight_matrix_loader.sv
module tb_weight_matrix_loader;

  localparam int unsigned FW = 32;
  localparam int unsigned DW = 512;
  localparam int unsigned MS = 32;
  localparam int unsigned KS = 3;
  localparam int unsigned CW = 16;
  localparam int PKG_NUM = (MS * KS * KS) / (DW / FW);  // 18
  localparam int BUDGET  = 2000;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic [CW-1:0] num_matrix_i;
  logic [DW-1:0] data_i;
  logic          data_valid_i;
  logic          data_ready_o;
  logic          en_o;
  logic          sel_w_o;
  logic [DW-1:0] data_o;
  logic          sel_r_o;
  logic          weight_valid_o;
  logic          release_i;
  logic          busy_o;
  logic          done_o;

  weight_matrix_loader #(.FW(FW), .DW(DW), .MS(MS), .KS(KS), .CW(CW)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .num_matrix_i   (num_matrix_i),
    .data_i         (data_i),
    .data_valid_i   (data_valid_i),
    .data_ready_o   (data_ready_o),
    .en_o           (en_o),
    .sel_w_o        (sel_w_o),
    .data_o         (data_o),
    .sel_r_o        (sel_r_o),
    .weight_valid_o (weight_valid_o),
    .release_i      (release_i),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint        cyc;
    logic [DW-1:0] data;
    logic          bank;
    bit            last;
  } exp_t;

  exp_t   sbq[$];
  int     checks   = 0;
  int     failures = 0;
  longint cyc      = 0;

  // Monitor-side model: matrices fully latched, matrices released, job state.
  int released = 0, complete = 0, pend_rel = 0;
  bit job_active = 0, job_active_nxt = 0, done_nxt = 0, exp_done = 0;
  int job_num = 0, job_base = 0;
  bit popped_last;

  // Driver-side model: packages accepted since reset.
  int acc_total = 0;
  int job_pkgs  = 0;

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: checks outputs each negedge against the scoreboard and model.
  always @(negedge clk) begin
    if (rst_i) begin
      sbq.delete();
      released = 0; complete = 0; pend_rel = 0;
      job_active = 0; job_active_nxt = 0; done_nxt = 0; exp_done = 0;
    end else begin
      released   += pend_rel;
      pend_rel    = 0;
      job_active  = job_active_nxt;
      exp_done    = done_nxt;
      popped_last = 0;

      chk_b("busy_o", busy_o, job_active);
      chk_b("done_o", done_o, exp_done);
      chk_b("weight_valid_o", weight_valid_o, (complete - released) > 0);
      chk_b("sel_r_o", sel_r_o, (released % 2) == 1);

      while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
        failures++; checks++;
        $display("FAIL en_missing cyc=%0d actual=no_en required=en_at_%0d", cyc, sbq[0].cyc);
        void'(sbq.pop_front());
      end
      if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
        chk_b("en_o", en_o, 1'b1);
        chk_w("data_o", data_o, sbq[0].data);
        chk_b("sel_w_o", sel_w_o, sbq[0].bank);
        popped_last = sbq[0].last;
        void'(sbq.pop_front());
      end else begin
        chk_b("en_o_idle", en_o, 1'b0);
      end

      pend_rel = (release_i && (complete - released) > 0) ? 1 : 0;
      done_nxt = 0;
      if (!job_active && start_i) begin
        if (num_matrix_i == '0) done_nxt = 1;
        else begin
          job_active_nxt = 1;
          job_num  = int'(num_matrix_i);
          job_base = released;
        end
      end else if (job_active && (released - job_base) == job_num) begin
        done_nxt = 1;
        job_active_nxt = 0;
      end
      if (popped_last) complete++;
    end
  end

  task automatic drive_idle();
    start_i = 0; data_valid_i = 0; release_i = 0; num_matrix_i = '0;
  endtask

  // One job: start at jc=0, random valid/release, optional stray start and abort.
  task automatic run_job(input int num, input int vpct, input int rpct, input int rdelay,
                         input bit idx_data, input bit poke_start, input int abort_at);
    bit loading  = 0;
    bit got_done = 0;
    logic exp_rdy;
    job_pkgs = 0;
    for (int jc = 0; jc < BUDGET && !got_done; jc++) begin
      @(posedge clk); #1;
      start_i      = (jc == 0) || (poke_start && jc == 5);
      num_matrix_i = (jc == 0) ? CW'(num) : CW'(5);
      data_valid_i = ($urandom_range(99) < vpct);
      if (idx_data) data_i = DW'(job_pkgs);
      else for (int k = 0; k < int'(DW / 32); k++) data_i[k*32 +: 32] = $urandom();
      release_i    = (jc >= rdelay) && ($urandom_range(99) < rpct);
      #6;
      exp_rdy = loading && (job_pkgs < num * PKG_NUM) && ((acc_total / PKG_NUM) - released) < 2;
      chk_b("data_ready_o", data_ready_o, exp_rdy);
      if (exp_rdy && data_valid_i) begin
        sbq.push_back('{cyc: cyc + 1, data: data_i, bank: ((acc_total / PKG_NUM) % 2) == 1,
                        last: (acc_total % PKG_NUM) == PKG_NUM - 1});
        acc_total++;
        job_pkgs++;
      end
      if (jc == 0) loading = (num > 0);
      if (done_o) got_done = 1;
      if (abort_at >= 0 && job_pkgs == abort_at) return;
    end
    if (!got_done) begin
      checks++; failures++;
      $display("FAIL job_timeout num=%0d actual=no_done required=done", num);
    end
    @(posedge clk); #1;
    drive_idle();
  endtask

  initial begin
    rst_i = 1;
    drive_idle();
    data_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_b("rst_en_o", en_o, 1'b0);
    chk_b("rst_busy_o", busy_o, 1'b0);
    chk_b("rst_done_o", done_o, 1'b0);
    chk_b("rst_ready", data_ready_o, 1'b0);
    chk_b("rst_weight_valid", weight_valid_o, 1'b0);
    chk_b("rst_sel_r", sel_r_o, 1'b0);
    chk_b("rst_sel_w", sel_w_o, 1'b0);
    chk_w("rst_data_o", data_o, '0);
    @(posedge clk); #1 rst_i = 0;

    run_job(1, 100, 50, 25, 1'b1, 1'b0, -1);   // streaming, data = index
    run_job(3, 100, 30, 70, 1'b0, 1'b1, -1);   // both banks fill, stray start
    run_job(0, 50, 50, 0, 1'b0, 1'b0, -1);     // empty job
    run_job(4, 50, 20, 0, 1'b0, 1'b0, -1);     // random gaps
    run_job(2, 70, 40, 10, 1'b0, 1'b0, -1);

    // Reset during the second matrix of a job, with bank 0 still full.
    run_job(2, 100, 0, 1000, 1'b0, 1'b0, 25);
    @(posedge clk); #2 rst_i = 1;
    #1;
    chk_b("midrst_en_o", en_o, 1'b0);
    chk_b("midrst_busy_o", busy_o, 1'b0);
    chk_b("midrst_weight_valid", weight_valid_o, 1'b0);
    chk_b("midrst_ready", data_ready_o, 1'b0);
    drive_idle();
    acc_total = 0;
    job_pkgs  = 0;
    @(posedge clk); #1 rst_i = 0;

    run_job(1, 60, 50, 0, 1'b0, 1'b0, -1);
    repeat (5) @(posedge clk);
    #7 chk_i("scoreboard_empty", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
